// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and default widths for the memory port arbiter
package cpu_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_priority.sv
// rtl/arb_priority.sv - two-input priority pick, data first unless fetch is starved
module arb_priority (
  input  logic if_valid,
  input  logic mem_valid,
  input  logic starved,
  output logic grant_valid,
  output logic grant_if
);

  // Data wins ties; a starved fetch side takes the tie instead
  always_comb begin
    grant_valid = if_valid | mem_valid;
    grant_if    = if_valid & (~mem_valid | starved);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single RAM port shared by instruction fetch and data access
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = CPU_ADDR_W,
  parameter int DATA_W       = CPU_DATA_W,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic              internal_clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  input  logic              halted,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              bus_err,
  output logic              busy
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 2);
  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              flushed_q, flushed_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [TO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic              bus_err_q, bus_err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic              grant_valid, grant_if;
  logic              start, ram_done, timed_out, finish, drop_fetch;
  logic [DATA_W-1:0] resp_data;

  // A fetch presented together with flush is treated as absent
  arb_priority u_arb (
    .if_valid    (if_req & ~flush),
    .mem_valid   (mem_req),
    .starved     (starve_cnt_q == SC_W'(STARVE_LIMIT)),
    .grant_valid (grant_valid),
    .grant_if    (grant_if)
  );

  // Transaction events derived from the current state
  always_comb begin
    start      = (state_q == ST_IDLE) && !halted && grant_valid;
    ram_done   = (state_q == ST_ACCESS) && ram_ready;
    timed_out  = (state_q == ST_ACCESS) && !ram_ready && (tmo_cnt_q == TO_W'(TIMEOUT - 1));
    finish     = ram_done || timed_out;
    drop_fetch = (owner_q == OWN_IF) && (flushed_q || flush);
    resp_data  = ram_done ? ram_rdata : '0;
  end

  // State register
  always_ff @(posedge internal_clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: RESP always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start)  state_d = ST_ACCESS;
      ST_ACCESS: if (finish) state_d = ST_RESP;
      ST_RESP:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; operands are only sampled on a grant
  always_comb begin
    owner_d      = owner_q;
    flushed_d    = flushed_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    ram_req_d    = ram_req_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    bus_err_d    = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          owner_d     = grant_if ? OWN_IF : OWN_MEM;
          flushed_d   = 1'b0;
          tmo_cnt_d   = '0;
          ram_req_d   = 1'b1;
          ram_we_d    = !grant_if && mem_we;
          ram_addr_d  = grant_if ? if_addr : mem_addr;
          ram_wdata_d = grant_if ? '0 : mem_wdata;
          // Count data grants that made a waiting fetch wait; saturate at the limit
          if (grant_if || !if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        flushed_d = flushed_q || ((owner_q == OWN_IF) && flush);
        if (finish) begin
          ram_req_d = 1'b0;
          if (owner_q == OWN_MEM) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = resp_data;
            bus_err_d   = timed_out;
          end else if (!drop_fetch) begin
            if_ack_d   = 1'b1;
            if_rdata_d = resp_data;
            bus_err_d  = timed_out;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge internal_clock or posedge reset) begin
    if (reset) begin
      owner_q      <= OWN_IF;
      flushed_q    <= 1'b0;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      flushed_q    <= flushed_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ram_req_q    <= ram_req_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      bus_err_q    <= bus_err_d;
      busy_q       <= busy_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic       internal_clock = 1'b0;
  logic       reset;
  logic       if_req, mem_req, mem_we, flush, halted;
  logic [7:0] if_addr, mem_addr, mem_wdata;
  logic       if_ack, mem_ack, ram_req, ram_we, bus_err, busy;
  logic [7:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic [7:0] ram_rdata;
  logic       ram_ready;

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(3), .TIMEOUT(15)
  ) dut (
    .internal_clock(internal_clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flush(flush), .halted(halted),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .bus_err(bus_err), .busy(busy)
  );

  always #5 internal_clock = ~internal_clock;

  typedef struct { logic [7:0] addr; logic we; logic [7:0] wdata; } grant_t;
  typedef struct { bit is_if; logic [7:0] data; bit chk_data; bit err; } resp_t;

  grant_t     exp_grant_q[$];
  resp_t      exp_resp_q[$];
  grant_t     mon_g;
  resp_t      mon_r;
  logic [7:0] ram_mem [256];
  logic [7:0] ref_mem [256];
  int         ready_lat = 0;
  int         acc_cnt = 0;
  int         ack_count = 0;
  int         req_len = 0;
  int         last_req_len = 0;
  logic       prev_ram_req = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_grant(input logic [7:0] addr, input logic we, input logic [7:0] wdata);
    grant_t g;
    g.addr = addr; g.we = we; g.wdata = wdata;
    exp_grant_q.push_back(g);
  endtask

  task automatic push_resp(input bit is_if, input logic [7:0] data, input bit chk_data, input bit err);
    resp_t r;
    r.is_if = is_if; r.data = data; r.chk_data = chk_data; r.err = err;
    exp_resp_q.push_back(r);
  endtask

  task automatic wait_acks(input int target, input string tag);
    for (int i = 0; i < 200 && ack_count < target; i++) begin
      @(negedge internal_clock); #1;
    end
    check(tag, ack_count, target);
  endtask

  task automatic run_txn(input bit is_if, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata, input bit err, input string tag);
    int target;
    push_grant(addr, is_if ? 1'b0 : we, is_if ? 8'h00 : wdata);
    if (err)     push_resp(is_if, 8'h00, 1'b1, 1'b1);
    else if (we) push_resp(is_if, 8'h00, 1'b0, 1'b0);
    else         push_resp(is_if, ref_mem[addr], 1'b1, 1'b0);
    if (!err && we && !is_if) ref_mem[addr] = wdata;
    target = ack_count + 1;
    @(negedge internal_clock); #1;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    end
    wait_acks(target, tag);
    if_req = 1'b0; mem_req = 1'b0;
  endtask

  // RAM model: ready after ready_lat ACCESS cycles, random ready noise while idle
  always @(negedge internal_clock) begin
    if (ram_req) begin
      if (ready_lat >= 0 && acc_cnt >= ready_lat) begin
        ram_ready = 1'b1;
        ram_rdata = ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] = ram_wdata;
      end else begin
        ram_ready = 1'b0;
        ram_rdata = 8'($urandom);
      end
      acc_cnt++;
    end else begin
      ram_ready = 1'($urandom);
      ram_rdata = 8'($urandom);
      acc_cnt = 0;
    end
  end

  // Monitor: grants and responses checked against the scoreboard queues
  always @(negedge internal_clock) begin
    if (!reset) begin
      if (ram_req && !prev_ram_req) begin
        check("grant_pending", exp_grant_q.size() != 0, 1);
        if (exp_grant_q.size() != 0) begin
          mon_g = exp_grant_q.pop_front();
          check("grant_addr", ram_addr, mon_g.addr);
          check("grant_we", ram_we, mon_g.we);
          if (mon_g.we) check("grant_wdata", ram_wdata, mon_g.wdata);
        end
        req_len = 0;
      end
      if (ram_req) req_len++;
      if (!ram_req && prev_ram_req) last_req_len = req_len;
      if (if_ack || mem_ack || bus_err) begin
        ack_count++;
        check("resp_pending", exp_resp_q.size() != 0, 1);
        if (exp_resp_q.size() != 0) begin
          mon_r = exp_resp_q.pop_front();
          check("resp_if_ack", if_ack, mon_r.is_if);
          check("resp_mem_ack", mem_ack, !mon_r.is_if);
          check("resp_bus_err", bus_err, mon_r.err);
          if (mon_r.chk_data) check("resp_rdata", mon_r.is_if ? if_rdata : mem_rdata, mon_r.data);
        end
      end
    end
    prev_ram_req = ram_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int seen;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    ram_mem[8'h10] = 8'hA5;
    ref_mem[8'h10] = 8'hA5;
    reset = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; flush = 0; halted = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0;

    // Reset state
    repeat (2) @(negedge internal_clock);
    #1;
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {if_ack, mem_ack, bus_err}, 0);
    check("rst_rdata", {if_rdata, mem_rdata}, 0);
    reset = 1'b0;

    // Fetch-only read with minimum latency
    ready_lat = 0;
    push_grant(8'h10, 1'b0, 8'h00);
    push_resp(1'b1, 8'hA5, 1'b1, 1'b0);
    @(negedge internal_clock); #1;
    if_req = 1'b1; if_addr = 8'h10;
    @(posedge internal_clock); #1;
    check("lat_ram_req", ram_req, 1);
    check("lat_no_early_ack", if_ack, 0);
    @(posedge internal_clock); #1;
    check("lat_if_ack", if_ack, 1);
    check("lat_if_rdata", if_rdata, 8'hA5);
    if_req = 1'b0;
    @(posedge internal_clock); #1;
    check("lat_ack_one_cycle", if_ack, 0);
    check("lat_idle", busy, 0);

    // Continuous contention: MEM,MEM,MEM,IF repeated
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        push_grant(8'h40, 1'b0, 8'h00);
        push_resp(1'b0, ref_mem[8'h40], 1'b1, 1'b0);
      end
      push_grant(8'h20, 1'b0, 8'h00);
      push_resp(1'b1, ref_mem[8'h20], 1'b1, 1'b0);
    end
    base = ack_count;
    @(negedge internal_clock); #1;
    if_req = 1'b1; if_addr = 8'h20;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h40;
    wait_acks(base + 8, "arb_acks");
    if_req = 1'b0; mem_req = 1'b0;
    check("arb_grants_used", exp_grant_q.size(), 0);

    // Flush during fetch ACCESS: access completes silently
    ready_lat = 2;
    push_grant(8'h30, 1'b0, 8'h00);
    base = ack_count;
    @(negedge internal_clock); #1;
    if_req = 1'b1; if_addr = 8'h30;
    @(posedge internal_clock); #1;
    check("flush_granted", ram_req, 1);
    @(negedge internal_clock); #1;
    flush = 1'b1; if_req = 1'b0;
    @(negedge internal_clock); #1;
    flush = 1'b0;
    repeat (6) @(negedge internal_clock);
    #1;
    check("flush_no_ack", ack_count, base);
    check("flush_rdata_kept", if_rdata, ref_mem[8'h20]);
    check("flush_idle", {busy, ram_req}, 0);

    // Fetch with flush in IDLE is ignored
    @(negedge internal_clock); #1;
    if_req = 1'b1; if_addr = 8'h11; flush = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge internal_clock);
      if (ram_req) seen++;
    end
    #1;
    check("flush_idle_no_grant", seen, 0);
    if_req = 1'b0; flush = 1'b0;

    // Store with RAM never ready: timeout
    ready_lat = -1;
    run_txn(1'b0, 1'b1, 8'h80, 8'h3C, 1'b1, "tmo_ack");
    check("tmo_req_cycles", last_req_len, 15);

    // Successful store then load back
    ready_lat = 1;
    run_txn(1'b0, 1'b1, 8'h55, 8'h77, 1'b0, "store_ack");
    run_txn(1'b0, 1'b0, 8'h55, 8'h00, 1'b0, "load_ack");
    run_txn(1'b1, 1'b0, 8'h66, 8'h00, 1'b0, "fetch_ack");

    // Halted blocks grants until released
    ready_lat = 0;
    @(negedge internal_clock); #1;
    halted = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h41;
    seen = 0;
    repeat (4) begin
      @(negedge internal_clock);
      if (ram_req || busy) seen++;
    end
    #1;
    check("halt_no_grant", seen, 0);
    push_grant(8'h41, 1'b0, 8'h00);
    push_resp(1'b0, ref_mem[8'h41], 1'b1, 1'b0);
    base = ack_count;
    halted = 1'b0;
    @(posedge internal_clock); #1;
    check("halt_release_grant", ram_req, 1);
    wait_acks(base + 1, "halt_ack");
    mem_req = 1'b0;

    // Reset in the middle of an ACCESS
    ready_lat = -1;
    push_grant(8'h42, 1'b0, 8'h00);
    @(negedge internal_clock); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h42;
    @(posedge internal_clock); #1;
    check("rst_mid_granted", ram_req, 1);
    @(posedge internal_clock);
    @(negedge internal_clock); #1;
    reset = 1'b1;
    #1;
    check("rst_mid_ram_req", ram_req, 0);
    check("rst_mid_busy", busy, 0);
    mem_req = 1'b0;
    @(posedge internal_clock);
    @(negedge internal_clock); #1;
    reset = 1'b0;
    ready_lat = 0;
    base = ack_count;
    repeat (20) @(negedge internal_clock);
    #1;
    check("rst_mid_no_ack", ack_count, base);
    check("rst_mid_idle", {busy, ram_req}, 0);

    check("grant_q_empty", exp_grant_q.size(), 0);
    check("resp_q_empty", exp_resp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
